// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter and the sequence detectors it drives.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

  localparam logic [3:0] SEQ_DEFAULT_PATTERN  = 4'b0110;
  localparam logic       SEQ_DEFAULT_IDLE_LVL = 1'b1;

endpackage

// File: rtl/pattern_shreg.sv
// WIDTH-bit load / shift-left register; msb is the serial tap. Load wins over shift.
module pattern_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             msb
);

  logic [WIDTH-1:0] shreg_q;

  // shift register state
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= {WIDTH{1'b0}};
    end else if (load) begin
      shreg_q <= d;
    end else if (shift) begin
      shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
    end else begin
      shreg_q <= shreg_q;
    end
  end

  assign msb = shreg_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first repeat_cnt+1 times,
// optionally separated by one idle bit, then pulses done.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int   WIDTH    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_LVL = SEQ_DEFAULT_IDLE_LVL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             gap_en,
  input  logic             abort,
  output logic             q,
  output logic             valid,
  output logic             ready,
  output logic             done
);

  localparam int               BIT_W    = $clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [CNT_W-1:0] REP_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             gap_q, gap_d;

  logic             sh_load;
  logic             sh_shift;
  logic [WIDTH-1:0] sh_d;
  logic             sh_msb;

  pattern_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (sh_load),
    .shift (sh_shift),
    .d     (sh_d),
    .msb   (sh_msb)
  );

  // state and burst-parameter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= {WIDTH{1'b0}};
      rep_q   <= REP_ZERO;
      bit_q   <= BIT_ZERO;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
    end
  end

  // next-state, counters and shift-register control
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    rep_d    = rep_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_d     = pat_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pat_d   = pattern;
          rep_d   = repeat_cnt;
          gap_d   = gap_en;
          bit_d   = BIT_LAST;
          sh_load = 1'b1;
          sh_d    = pattern;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_DONE;
        end else if (bit_q != BIT_ZERO) begin
          sh_shift = 1'b1;
          bit_d    = bit_q - BIT_W'(1);
        end else if (rep_q == REP_ZERO) begin
          state_d = ST_DONE;
        end else begin
          // last bit of a repetition: reload so the next pattern follows seamlessly
          rep_d   = rep_q - REP_ONE;
          bit_d   = BIT_LAST;
          sh_load = 1'b1;
          state_d = gap_q ? ST_GAP : ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore output decode from state and the shift register tap
  always_comb begin
    q     = IDLE_LVL;
    valid = 1'b0;
    ready = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_SHIFT: begin
        q     = sh_msb;
        valid = 1'b1;
      end
      ST_GAP: begin
        q = IDLE_LVL;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        q = IDLE_LVL;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed self-checking bench for seq_pattern_tx; each check compares {q,valid,ready,done}
// or a bench-side count against hand-derived values.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeat_cnt;
  logic       gap_en;
  logic       abort;
  logic       q, valid, ready, done;

  int vectors    = 0;
  int miscompares = 0;
  int vcnt       = 0;
  int det_cnt    = 0;
  int det_bits   = 0;
  logic [3:0] det_win = 4'b0000;

  seq_pattern_tx #(
    .WIDTH    (4),
    .CNT_W    (4),
    .IDLE_LVL (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .gap_en     (gap_en),
    .abort      (abort),
    .q          (q),
    .valid      (valid),
    .ready      (ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, q, valid, ready, done};
  endfunction

  // n cycles of expected {q,valid}, MSB-first in qs/vs; also feeds a 0110 detector model
  task automatic expect_seq(input string tag, input logic [63:0] qs, input logic [63:0] vs,
                            input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, outs(), {28'd0, qs[n-1-i], vs[n-1-i], 1'b0, 1'b0});
      if (valid === 1'b1) begin
        vcnt++;
        det_bits++;
        det_win = {det_win[2:0], q};
        if (det_bits >= 4 && det_win == SEQ_DEFAULT_PATTERN) det_cnt++;
      end
      tick();
    end
  endtask

  task automatic launch(input logic [3:0] pat, input logic [3:0] rep, input logic gap);
    start      = 1'b1;
    pattern    = pat;
    repeat_cnt = rep;
    gap_en     = gap;
    tick();
    start = 1'b0;
  endtask

  task automatic expect_done_ready(input string tag);
    chk({tag, "_done"}, outs(), 32'h9);
    tick();
    chk({tag, "_ready"}, outs(), 32'hA);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pattern = 4'b0000; repeat_cnt = 4'd0;
    gap_en = 1'b0; abort = 1'b0;

    // reset held three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", outs(), 32'hA);
    end
    reset = 1'b0;

    // single pattern
    launch(4'b0110, 4'd0, 1'b0);
    expect_seq("single", 64'b0110, 64'b1111, 4);
    expect_done_ready("single");

    // three repetitions, no gap, into a 0110 detector model
    det_cnt = 0; det_bits = 0; det_win = 4'b0000;
    launch(4'b0110, 4'd2, 1'b0);
    expect_seq("rep_nogap", 64'b0110_0110_0110, 64'hFFF, 12);
    expect_done_ready("rep_nogap");
    chk("detect_count", det_cnt, 32'd3);

    // two repetitions with gap
    launch(4'b1011, 4'd1, 1'b1);
    expect_seq("rep_gap", 64'b1011_1_1011, 64'b1111_0_1111, 9);
    expect_done_ready("rep_gap");

    // abort on third bit of a four-pattern burst
    vcnt = 0;
    launch(4'b1010, 4'd3, 1'b0);
    expect_seq("abort_pre", 64'b10, 64'b11, 2);
    abort = 1'b1;
    chk("abort_bit", outs(), 32'hC);
    vcnt++;
    tick();
    abort = 1'b0;
    expect_done_ready("abort");
    chk("abort_vcnt", vcnt, 32'd3);

    // start and input changes during the burst are ignored
    launch(4'b0110, 4'd1, 1'b0);
    start = 1'b1; pattern = 4'b1111; repeat_cnt = 4'd0; gap_en = 1'b1;
    expect_seq("ignored", 64'b0110_0110, 64'hFF, 8);
    chk("ignored_done", outs(), 32'h9);
    start = 1'b0;
    tick();
    chk("ignored_ready", outs(), 32'hA);
    tick();
    chk("no_second_burst", outs(), 32'hA);

    // reset during GAP, then a fresh burst one cycle after release
    launch(4'b1100, 4'd1, 1'b1);
    expect_seq("pre_gap", 64'b1100, 64'b1111, 4);
    chk("in_gap", outs(), 32'h8);
    reset = 1'b1;
    tick();
    chk("reset_mid", outs(), 32'hA);
    reset = 1'b0;
    tick();
    chk("after_reset", outs(), 32'hA);
    launch(4'b0101, 4'd0, 1'b0);
    expect_seq("post_reset", 64'b0101, 64'b1111, 4);
    expect_done_ready("post_reset");

    // repeat_cnt all ones gives 16 patterns
    vcnt = 0;
    launch(4'b0011, 4'hF, 1'b0);
    expect_seq("max_rep", 64'h3333_3333_3333_3333, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    expect_done_ready("max_rep");
    chk("max_rep_vcnt", vcnt, 32'd64);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
